// File: rtl/pdh_capture_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pdh_capture_pkg: shared capture types, beat geometry and sign-extension
// Revision: 1.0
// ----------------------------------------------------------------------------
package pdh_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } capture_state_t;

   localparam int BEAT_WIDTH     = 64;
   localparam int LANE_WIDTH     = 16;
   localparam int PAIRS_PER_BEAT = 2;

   // Treats the low src_width bits of raw as a two's-complement value.
   function automatic logic [LANE_WIDTH-1:0] sign_ext(input logic [LANE_WIDTH-1:0] raw,
                                                       input int src_width);
      logic signed [LANE_WIDTH-1:0] tmp;
      tmp = raw << (LANE_WIDTH - src_width);
      return tmp >>> (LANE_WIDTH - src_width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dma_sample_packer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_sample_packer_if: valid/ready beat stream towards the DMA write engine
// Revision: 1.0
// ----------------------------------------------------------------------------
interface dma_sample_packer_if;
   import pdh_capture_pkg::*;

   logic [BEAT_WIDTH-1:0] m_data_o;
   logic                  m_valid_o;
   logic                  m_ready_i;

   modport master (output m_data_o, output m_valid_o, input m_ready_i);
   modport slave  (input m_data_o, input m_valid_o, output m_ready_i);

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo: single-clock first-word fall-through FIFO with flush
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_addr_w:0] r_wr_ptr;
   logic [c_addr_w:0] r_rd_ptr;
   logic              w_rd_fire;
   logic              w_wr_fire;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                  (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

   // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign w_rd_fire = rd_en && !empty;
   assign w_wr_fire = wr_en && (!full || w_rd_fire);

   assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_addr_w-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_fire) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_rd_fire) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_fire && !flush) r_mem[r_wr_ptr[c_addr_w-1:0]] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/dma_sample_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_sample_packer: decimate, sign-extend and pack A/B sample pairs into beats
// Revision: 1.0
// ----------------------------------------------------------------------------
module dma_sample_packer
   import pdh_capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 14,
   parameter int FIFO_DEPTH   = 16,
   parameter int LEN_WIDTH    = 20,
   parameter int DEC_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    arm_i,
   input  logic                    abort_i,
   input  logic                    trig_i,
   input  logic [DEC_WIDTH-1:0]    decim_i,
   input  logic [LEN_WIDTH-1:0]    frame_len_i,
   input  logic                    sample_valid_i,
   input  logic [SAMPLE_WIDTH-1:0] sample_a_i,
   input  logic [SAMPLE_WIDTH-1:0] sample_b_i,
   dma_sample_packer_if.master     m,
   output logic [1:0]              state_o,
   output logic                    done_o,
   output logic                    overflow_o,
   output logic [LEN_WIDTH-1:0]    beat_cnt_o
);

   localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
   localparam logic [DEC_WIDTH-1:0] c_dec_one = DEC_WIDTH'(1);
   localparam int c_lo_width = (PAIRS_PER_BEAT - 1) * 2 * LANE_WIDTH;

   capture_state_t r_state;
   capture_state_t w_next_state;

   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_beat_cnt;
   logic [LEN_WIDTH-1:0]  w_cnt_next;
   logic [DEC_WIDTH-1:0]  r_decim;
   logic [DEC_WIDTH-1:0]  r_dec_cnt;
   logic                  r_half;
   logic                  r_beat_vld;
   logic                  r_done;
   logic                  r_overflow;
   logic [c_lo_width-1:0] r_pack_lo;
   logic [BEAT_WIDTH-1:0] r_beat;
   logic [BEAT_WIDTH-1:0] w_fifo_data;
   logic [LANE_WIDTH-1:0] w_lane_a;
   logic [LANE_WIDTH-1:0] w_lane_b;
   logic w_fifo_full, w_fifo_empty;
   logic w_push, w_drop, w_len_hit, w_do_arm, w_trig_hit, w_take, w_keep;

   assign w_lane_a   = sign_ext(LANE_WIDTH'(sample_a_i), SAMPLE_WIDTH);
   assign w_lane_b   = sign_ext(LANE_WIDTH'(sample_b_i), SAMPLE_WIDTH);
   assign w_cnt_next = r_beat_cnt + c_len_one;
   assign w_push     = r_beat_vld && !abort_i;
   assign w_len_hit  = w_push && (w_cnt_next == r_len);
   assign w_drop     = w_push && w_fifo_full && !m.m_ready_i;
   assign w_do_arm   = (r_state == ST_IDLE) && arm_i && !abort_i;
   assign w_trig_hit = (r_state == ST_ARMED) && trig_i && !abort_i;
   // Samples arriving on the cycle the final beat is pushed belong to no frame.
   assign w_take     = (r_state == ST_CAPTURE) && sample_valid_i && !w_len_hit && !abort_i;
   assign w_keep     = w_take && (r_dec_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (abort_i) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (arm_i) w_next_state = ST_ARMED;
            ST_ARMED:   if (trig_i) w_next_state = (r_len == '0) ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE: if (w_len_hit) w_next_state = ST_DRAIN;
            ST_DRAIN:   if (w_fifo_empty) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= '0;
         r_decim    <= '0;
         r_dec_cnt  <= '0;
         r_beat_cnt <= '0;
         r_half     <= 1'b0;
         r_beat_vld <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_pack_lo  <= '0;
         r_beat     <= '0;
      end else if (abort_i) begin
         r_half     <= 1'b0;
         r_beat_vld <= 1'b0;
         r_dec_cnt  <= '0;
      end else begin
         r_beat_vld <= 1'b0;
         if (w_push) begin
            r_beat_cnt <= w_cnt_next;
            if (w_drop) r_overflow <= 1'b1;
         end
         if (w_do_arm) begin
            r_len      <= frame_len_i;
            r_decim    <= decim_i;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_beat_cnt <= '0;
            r_half     <= 1'b0;
         end
         if (w_trig_hit) begin
            r_dec_cnt <= '0;
            r_half    <= 1'b0;
         end
         if ((r_state == ST_DRAIN) && w_fifo_empty) r_done <= 1'b1;
         if (w_take) r_dec_cnt <= (r_dec_cnt == r_decim) ? '0 : r_dec_cnt + c_dec_one;
         if (w_keep) begin
            if (!r_half) begin
               r_pack_lo <= {w_lane_b, w_lane_a};
               r_half    <= 1'b1;
            end else begin
               r_beat     <= {w_lane_b, w_lane_a, r_pack_lo};
               r_beat_vld <= 1'b1;
               r_half     <= 1'b0;
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (BEAT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (abort_i),
      .wr_en   (w_push),
      .wr_data (r_beat),
      .rd_en   (m.m_ready_i),
      .rd_data (w_fifo_data),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   assign m.m_data_o  = w_fifo_data;
   assign m.m_valid_o = !w_fifo_empty;
   assign state_o     = r_state;
   assign done_o      = r_done;
   assign overflow_o  = r_overflow;
   assign beat_cnt_o  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dma_sample_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dma_sample_packer: directed self-checking bench for dma_sample_packer
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dma_sample_packer;

   localparam int SW = 14;
   localparam int LW = 20;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          trig_i = 1'b0;
   logic [DW-1:0] decim_i = '0;
   logic [LW-1:0] frame_len_i = '0;
   logic          sample_valid_i = 1'b0;
   logic [SW-1:0] sample_a_i = '0;
   logic [SW-1:0] sample_b_i = '0;
   logic [1:0]    state_o;
   logic          done_o;
   logic          overflow_o;
   logic [LW-1:0] beat_cnt_o;

   int n_pass = 0;
   int n_total = 0;
   logic [63:0] q_beats[$];

   dma_sample_packer_if u_if();

   dma_sample_packer #(
      .SAMPLE_WIDTH (SW),
      .FIFO_DEPTH   (16),
      .LEN_WIDTH    (LW),
      .DEC_WIDTH    (DW)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .arm_i          (arm_i),
      .abort_i        (abort_i),
      .trig_i         (trig_i),
      .decim_i        (decim_i),
      .frame_len_i    (frame_len_i),
      .sample_valid_i (sample_valid_i),
      .sample_a_i     (sample_a_i),
      .sample_b_i     (sample_b_i),
      .m              (u_if.master),
      .state_o        (state_o),
      .done_o         (done_o),
      .overflow_o     (overflow_o),
      .beat_cnt_o     (beat_cnt_o)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after posedge, so negedge values are what the next edge sees.
   always @(negedge clk) begin
      if (rst_n && u_if.m_valid_o && u_if.m_ready_i) q_beats.push_back(u_if.m_data_o);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_arm(input int len, input int dec);
      frame_len_i = LW'(len);
      decim_i     = DW'(dec);
      arm_i       = 1'b1;
      tick(1);
      arm_i       = 1'b0;
   endtask

   task automatic do_trig();
      trig_i = 1'b1;
      tick(1);
      trig_i = 1'b0;
   endtask

   task automatic send_pair(input int a, input int b);
      sample_valid_i = 1'b1;
      sample_a_i     = SW'(a);
      sample_b_i     = SW'(b);
      tick(1);
      sample_valid_i = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] st, input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (state_o == st) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      tick(3);
      n_total++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
      n_total++; if (u_if.m_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", u_if.m_valid_o); else n_pass++;
      n_total++; if (u_if.m_data_o !== 64'h0) $display("FAIL reset_data: got %h want 0", u_if.m_data_o); else n_pass++;
      n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
      n_total++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else n_pass++;
      n_total++; if (beat_cnt_o !== '0) $display("FAIL reset_cnt: got %0d want 0", beat_cnt_o); else n_pass++;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic_pack();
      bit ok;
      u_if.m_ready_i = 1'b1;
      q_beats.delete();
      do_arm(2, 0);
      n_total++; if (state_o !== 2'd1) $display("FAIL basic_armed: got %0d want 1", state_o); else n_pass++;
      do_trig();
      n_total++; if (state_o !== 2'd2) $display("FAIL basic_capture: got %0d want 2", state_o); else n_pass++;
      send_pair(1, -1);
      send_pair(2, -2);
      send_pair(3, -3);
      send_pair(4, -4);
      wait_state(2'd0, 50, ok);
      n_total++; if (!ok) $display("FAIL basic_idle: got state %0d want 0", state_o); else n_pass++;
      n_total++; if (q_beats.size() !== 2) $display("FAIL basic_count: got %0d want 2", q_beats.size()); else n_pass++;
      if (q_beats.size() == 2) begin
         n_total++; if (q_beats[0] !== 64'hFFFE_0002_FFFF_0001) $display("FAIL basic_beat0: got %h want fffe0002ffff0001", q_beats[0]); else n_pass++;
         n_total++; if (q_beats[1] !== 64'hFFFC_0004_FFFD_0003) $display("FAIL basic_beat1: got %h want fffc0004fffd0003", q_beats[1]); else n_pass++;
      end
      n_total++; if (done_o !== 1'b1) $display("FAIL basic_done: got %b want 1", done_o); else n_pass++;
      n_total++; if (beat_cnt_o !== LW'(2)) $display("FAIL basic_cnt: got %0d want 2", beat_cnt_o); else n_pass++;
   endtask

   task automatic test_decimation();
      bit ok;
      u_if.m_ready_i = 1'b1;
      q_beats.delete();
      do_arm(1, 3);
      do_trig();
      for (int k = 0; k < 12; k++) send_pair(k, 100 + k);
      wait_state(2'd0, 50, ok);
      n_total++; if (!ok) $display("FAIL decim_idle: got state %0d want 0", state_o); else n_pass++;
      n_total++; if (q_beats.size() !== 1) $display("FAIL decim_count: got %0d want 1", q_beats.size()); else n_pass++;
      if (q_beats.size() == 1) begin
         n_total++; if (q_beats[0] !== 64'h0068_0004_0064_0000) $display("FAIL decim_beat: got %h want 0068000400640000", q_beats[0]); else n_pass++;
      end
      n_total++; if (done_o !== 1'b1) $display("FAIL decim_done: got %b want 1", done_o); else n_pass++;
   endtask

   task automatic test_overflow();
      bit ok;
      u_if.m_ready_i = 1'b0;
      do_arm(20, 0);
      do_trig();
      for (int i = 0; i < 40; i++) send_pair(i, i + 1000);
      tick(3);
      n_total++; if (state_o !== 2'd3) $display("FAIL ovf_state: got %0d want 3", state_o); else n_pass++;
      n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else n_pass++;
      n_total++; if (beat_cnt_o !== LW'(20)) $display("FAIL ovf_cnt: got %0d want 20", beat_cnt_o); else n_pass++;
      n_total++; if (u_if.m_data_o !== 64'h03E9_0001_03E8_0000) $display("FAIL ovf_head: got %h want 03e9000103e80000", u_if.m_data_o); else n_pass++;
      n_total++; if (done_o !== 1'b0) $display("FAIL ovf_not_done: got %b want 0", done_o); else n_pass++;
      q_beats.delete();
      u_if.m_ready_i = 1'b1;
      wait_state(2'd0, 100, ok);
      n_total++; if (!ok) $display("FAIL ovf_idle: got state %0d want 0", state_o); else n_pass++;
      n_total++; if (q_beats.size() !== 16) $display("FAIL ovf_drained: got %0d want 16", q_beats.size()); else n_pass++;
      if (q_beats.size() == 16) begin
         n_total++; if (q_beats[15] !== 64'h0407_001F_0406_001E) $display("FAIL ovf_last: got %h want 0407001f0406001e", q_beats[15]); else n_pass++;
      end
      n_total++; if (done_o !== 1'b1) $display("FAIL ovf_done: got %b want 1", done_o); else n_pass++;
   endtask

   task automatic test_abort();
      bit ok;
      u_if.m_ready_i = 1'b0;
      do_arm(4, 0);
      do_trig();
      send_pair(1, 1);
      send_pair(2, 2);
      send_pair(3, 3);
      n_total++; if (u_if.m_valid_o !== 1'b1) $display("FAIL abort_pre_valid: got %b want 1", u_if.m_valid_o); else n_pass++;
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      n_total++; if (state_o !== 2'd0) $display("FAIL abort_state: got %0d want 0", state_o); else n_pass++;
      n_total++; if (u_if.m_valid_o !== 1'b0) $display("FAIL abort_valid: got %b want 0", u_if.m_valid_o); else n_pass++;
      n_total++; if (done_o !== 1'b0) $display("FAIL abort_done: got %b want 0", done_o); else n_pass++;
      n_total++; if (beat_cnt_o !== LW'(1)) $display("FAIL abort_cnt: got %0d want 1", beat_cnt_o); else n_pass++;
      u_if.m_ready_i = 1'b1;
      q_beats.delete();
      do_arm(1, 0);
      do_trig();
      send_pair(5, -5);
      send_pair(6, -6);
      wait_state(2'd0, 50, ok);
      n_total++; if (!ok) $display("FAIL rearm_idle: got state %0d want 0", state_o); else n_pass++;
      n_total++; if (q_beats.size() !== 1) $display("FAIL rearm_count: got %0d want 1", q_beats.size()); else n_pass++;
      if (q_beats.size() == 1) begin
         n_total++; if (q_beats[0] !== 64'hFFFA_0006_FFFB_0005) $display("FAIL rearm_beat: got %h want fffa0006fffb0005", q_beats[0]); else n_pass++;
      end
      n_total++; if (done_o !== 1'b1) $display("FAIL rearm_done: got %b want 1", done_o); else n_pass++;
   endtask

   task automatic test_zero_len();
      bit ok;
      u_if.m_ready_i = 1'b1;
      q_beats.delete();
      do_arm(0, 0);
      n_total++; if (done_o !== 1'b0) $display("FAIL zlen_done_clr: got %b want 0", done_o); else n_pass++;
      do_trig();
      n_total++; if (state_o !== 2'd3) $display("FAIL zlen_drain: got %0d want 3", state_o); else n_pass++;
      wait_state(2'd0, 10, ok);
      n_total++; if (!ok) $display("FAIL zlen_idle: got state %0d want 0", state_o); else n_pass++;
      n_total++; if (done_o !== 1'b1) $display("FAIL zlen_done: got %b want 1", done_o); else n_pass++;
      n_total++; if (q_beats.size() !== 0) $display("FAIL zlen_beats: got %0d want 0", q_beats.size()); else n_pass++;
      arm_i   = 1'b1;
      abort_i = 1'b1;
      tick(1);
      arm_i   = 1'b0;
      abort_i = 1'b0;
      n_total++; if (state_o !== 2'd0) $display("FAIL arm_abort_state: got %0d want 0", state_o); else n_pass++;
   endtask

   task automatic test_async_reset();
      u_if.m_ready_i = 1'b0;
      do_arm(8, 0);
      do_trig();
      for (int i = 0; i < 10; i++) send_pair(i + 1, i + 1);
      tick(1);
      n_total++; if (beat_cnt_o !== LW'(5)) $display("FAIL arst_pre_cnt: got %0d want 5", beat_cnt_o); else n_pass++;
      n_total++; if (state_o !== 2'd2) $display("FAIL arst_pre_state: got %0d want 2", state_o); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (state_o !== 2'd0) $display("FAIL arst_state: got %0d want 0", state_o); else n_pass++;
      n_total++; if (u_if.m_valid_o !== 1'b0) $display("FAIL arst_valid: got %b want 0", u_if.m_valid_o); else n_pass++;
      n_total++; if (u_if.m_data_o !== 64'h0) $display("FAIL arst_data: got %h want 0", u_if.m_data_o); else n_pass++;
      n_total++; if (beat_cnt_o !== '0) $display("FAIL arst_cnt: got %0d want 0", beat_cnt_o); else n_pass++;
      n_total++; if (done_o !== 1'b0 || overflow_o !== 1'b0) $display("FAIL arst_flags: got done=%b ovf=%b want 0 0", done_o, overflow_o); else n_pass++;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      n_total++; if (u_if.m_valid_o !== 1'b0) $display("FAIL arst_post_valid: got %b want 0", u_if.m_valid_o); else n_pass++;
      n_total++; if (state_o !== 2'd0) $display("FAIL arst_post_state: got %0d want 0", state_o); else n_pass++;
   endtask

   initial begin
      u_if.m_ready_i = 1'b0;
      test_reset();
      test_basic_pack();
      test_decimation();
      test_overflow();
      test_abort();
      test_zero_len();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dma_sample_packer.md
Name: dma_sample_packer

Overview:
- Capture front-end that sits directly upstream of the HP0 DMA write engine, on the ADC/DAC sample clock.
- Decimates the two 14-bit ADC channels and sign-extends each sample to 16 bits.
- Packs two A/B sample pairs into each 64-bit beat and buffers the beats in a small FIFO.
- Presents the beats on a valid/ready stream that the DMA engine drains; arm/trigger/length control comes from the pdh_core register bank.

Parameters:
- SAMPLE_WIDTH, 14, ADC sample width (signed, two's complement).
- FIFO_DEPTH, 16, beat FIFO depth; power of two, ≥4.
- LEN_WIDTH, 20, width of the frame-length and beat counters.
- DEC_WIDTH, 16, width of the decimation ratio.

Ports:
- clk  in  1  sample clock; all logic is on this single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- arm_i  in  1  single-cycle pulse; arms a capture.
- abort_i  in  1  single-cycle pulse; cancels a capture and flushes.
- trig_i  in  1  trigger level/pulse, sampled while ARMED.
- decim_i  in  DEC_WIDTH  keep 1 of (decim_i+1) valid samples.
- frame_len_i  in  LEN_WIDTH  beats per frame; latched on arm.
- sample_valid_i  in  1  sample_a_i/sample_b_i are valid this cycle.
- sample_a_i  in  SAMPLE_WIDTH  channel A sample.
- sample_b_i  in  SAMPLE_WIDTH  channel B sample.
- m_data_o  out  64  packed beat.
- m_valid_o  out  1  beat available.
- m_ready_i  in  1  consumer accepts the beat.
- state_o  out  2  current FSM state.
- done_o  out  1  sticky; frame completed.
- overflow_o  out  1  sticky; at least one beat was dropped.
- beat_cnt_o  out  LEN_WIDTH  beats produced in the current frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state IDLE, FIFO empty, pack register cleared.
  - All outputs 0: m_data_o, m_valid_o, done_o, overflow_o, beat_cnt_o, state_o.
- State encoding (shared package): IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3.
- IDLE:
  - arm_i → ARMED.
  - On arm: latch frame_len_i and decim_i; clear done_o, overflow_o, beat_cnt_o and the half-word flag.
  - arm_i outside IDLE is ignored.
- ARMED:
  - trig_i=1 → CAPTURE, with the decimation counter set to 0.
  - The sample presented on the trigger cycle is not captured.
  - If the latched length is 0, trig_i → DRAIN instead.
- CAPTURE, decimation:
  - On each sample_valid_i, the sample is kept if dec_cnt==0.
  - dec_cnt increments on every valid sample and wraps to 0 after reaching the latched decim.
  - decim=0 keeps every valid sample.
- CAPTURE, packing:
  - Each channel is sign-extended to 16 bits.
  - First kept pair fills lanes [15:0]=A0 and [31:16]=B0.
  - Second kept pair fills [47:32]=A1 and [63:48]=B1, completing the beat.
- Beat push:
  - A completed beat is written to the FIFO on the next cycle; beat_cnt_o increments on that write cycle.
  - When beat_cnt reaches the latched length → DRAIN; further samples are ignored.
- Overflow:
  - If the FIFO is full at write time, the beat is dropped and overflow_o is set (sticky).
  - beat_cnt still increments, so frame timing stays deterministic.
- DRAIN: when the FIFO is empty → IDLE and done_o=1. done_o holds until the next arm.
- Abort:
  - abort_i in any state → IDLE next cycle; FIFO flushed, partial beat discarded, done_o not set.
  - overflow_o and beat_cnt_o keep their values.
  - abort_i wins over a simultaneous arm_i or trig_i.
- Output stream:
  - m_valid_o = FIFO not empty (first-word fall-through).
  - m_data_o is stable while m_valid_o && !m_ready_i.
  - Transfer occurs on m_valid_o && m_ready_i.
  - m_valid_o never depends combinationally on m_ready_i.
- Latency:
  - Second kept pair at cycle N → FIFO write at N+1 → m_valid_o at N+2 (FIFO previously empty).
- FIFO simultaneous read and write:
  - When full, a read frees a slot in the same cycle, so the write succeeds (no overflow).
  - When empty, the write lands and is visible the next cycle.
- Length and decimation changes: new frame_len_i/decim_i values take effect only at the next arm.

Decomposition:
- Package pdh_capture_pkg:
  - capture_state_t enum.
  - BEAT_WIDTH=64, LANE_WIDTH=16, PAIRS_PER_BEAT=2.
  - Sign-extension function.
- Sub-module sync_fifo:
  - Parameterised width/depth, first-word fall-through.
  - Ports: full, empty, flush.
  - Async active-low reset.
- The top level holds the FSM, decimator, packer and counters.

Test Plan:
- Arm, len=2, decim=0, trig, then A/B samples 1,-1 / 2,-2 / 3,-3 / 4,-4 with m_ready_i=1 → two beats, 0xFFFE_0002_FFFF_0001 then 0xFFFC_0004_FFFD_0003; done_o=1, beat_cnt_o=2, state IDLE.
- Decim=3, len=1, a continuous ramp starting at 0 after trig → one beat containing A-samples 0 and 4 only.
- m_ready_i=0, FIFO_DEPTH=16, len=20, continuous samples → 16 beats buffered, overflow_o=1, beat_cnt_o=20, state DRAIN. Then raise m_ready_i → 16 beats out, done_o=1.
- Abort after 3 samples of a len=4 frame → IDLE next cycle; m_valid_o=0, done_o=0; a re-arm works normally.
- Len=0, arm+trig → DRAIN then IDLE with done_o=1 and no beats out. arm and abort in the same cycle → state stays IDLE.
- Assert rst_n low mid-CAPTURE with the FIFO holding 5 beats → all outputs 0 immediately (asynchronous) and the FIFO is empty after release.
